axi_line_fill_master: RTL

AXI4 master that issues cache-line fills and single-word write-throughs on behalf of the Enokida n-way cache. It is the initiator end of the AXI memory ports that the simulation VIP slave memories answer. The cache raises a fill or write request; the block runs the AR/R or AW/W/B exchange and returns the assembled line or the write status.

---
 rtl/axi_line_fill_master_if.sv | 48 ++++
 rtl/axi_line_fill_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_fill_master_if.sv
// rtl/axi_line_fill_master_if.sv - AXI4 read/write channel bundle for the line-fill master

interface axi_line_fill_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready,
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_line_fill_master.sv
// rtl/axi_line_fill_master.sv - AXI4 master for cache line fills and single-word write-throughs
// Define CRITICAL_WORD_FIRST_EN for WRAP bursts starting at the missed word.

module axi_line_fill_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fill_req,
  input  logic [ADDR_WIDTH-1:0]          fill_addr,
  output logic                           fill_ready,
  output logic                           fill_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_line,
  output logic                           fill_error,
  input  logic                           wr_req,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic                           wr_ready,
  output logic                           wr_done,
  output logic                           wr_error,
  axi_line_fill_master_if.master         m_axi
);
  localparam int OFF_BITS  = $clog2(DATA_WIDTH/8);
  localparam int IDX_BITS  = $clog2(LINE_WORDS);
  localparam int BEAT_BITS = IDX_BITS + 1;
  localparam logic [BEAT_BITS-1:0]  LAST_BEAT  = BEAT_BITS'(LINE_WORDS - 1);
  localparam logic [BEAT_BITS-1:0]  FULL_BEATS = BEAT_BITS'(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ADDR_WIDTH'(DATA_WIDTH/8 - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ADDR_WIDTH'(LINE_WORDS*(DATA_WIDTH/8) - 1);
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] RD_BURST = 2'b10;
`else
  localparam logic [1:0] RD_BURST = 2'b01;
`endif

  typedef enum logic [2:0] {IDLE, AR, RDATA, AWW, BRESP} state_t;

  state_t                          state_q, state_d;
  logic [BEAT_BITS-1:0]            beat_q, beat_d;
  logic                            err_q, err_d;
  logic [ADDR_WIDTH-1:0]           araddr_q, araddr_d;
  logic                            arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]           awaddr_q, awaddr_d;
  logic                            awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]         wstrb_q, wstrb_d;
  logic                            wvalid_q, wvalid_d;
  logic [LINE_WORDS*DATA_WIDTH-1:0] fill_line_q, fill_line_d;
  logic                            fill_valid_q, fill_valid_d;
  logic                            fill_error_q, fill_error_d;
  logic                            wr_done_q, wr_done_d;
  logic                            wr_error_q, wr_error_d;
  logic [IDX_BITS-1:0]             idx;
  logic                            can_accept;
  logic                            r_err;
`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_BITS-1:0]             start_word_q, start_word_d;
`endif

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    err_d        = err_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wvalid_d     = wvalid_q;
    fill_line_d  = fill_line_q;
    fill_valid_d = 1'b0;
    fill_error_d = 1'b0;
    wr_done_d    = 1'b0;
    wr_error_d   = 1'b0;
    fill_ready   = 1'b0;
    wr_ready     = 1'b0;
    r_err        = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
    start_word_d = start_word_q;
    idx          = start_word_q + beat_q[IDX_BITS-1:0];
`else
    idx          = beat_q[IDX_BITS-1:0];
`endif
    // The completion-pulse cycle is still IDLE but must not accept a new request.
    can_accept = !fill_valid_q && !wr_done_q;

    case (state_q)
      IDLE: begin
        if (can_accept && fill_req) begin
          fill_ready = 1'b1;
          arvalid_d  = 1'b1;
          beat_d     = '0;
          err_d      = 1'b0;
          state_d    = AR;
`ifdef CRITICAL_WORD_FIRST_EN
          araddr_d     = fill_addr & ~WORD_MASK;
          start_word_d = fill_addr[OFF_BITS +: IDX_BITS];
`else
          araddr_d     = fill_addr & ~LINE_MASK;
`endif
        end else if (can_accept && wr_req) begin
          wr_ready  = 1'b1;
          awaddr_d  = wr_addr;
          wdata_d   = wr_data;
          wstrb_d   = wr_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = AWW;
        end
      end
      AR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi.rvalid) begin
          r_err = err_q || (m_axi.rresp != 2'b00) || (beat_q >= FULL_BEATS) ||
                  (m_axi.rlast && (beat_q != LAST_BEAT));
          if (beat_q < FULL_BEATS) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
              if (IDX_BITS'(i) == idx) begin
                fill_line_d[i*DATA_WIDTH +: DATA_WIDTH] = m_axi.rdata;
              end
            end
            beat_d = beat_q + BEAT_BITS'(1);
          end
          if (m_axi.rlast) begin
            fill_valid_d = 1'b1;
            fill_error_d = r_err;
            beat_d       = '0;
            err_d        = 1'b0;
            state_d      = IDLE;
          end else begin
            err_d = r_err;
          end
        end
      end
      AWW: begin
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = BRESP;
      end
      BRESP: begin
        if (m_axi.bvalid) begin
          wr_done_d  = 1'b1;
          wr_error_d = (m_axi.bresp != 2'b00);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      err_q        <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      fill_line_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_error_q <= 1'b0;
      wr_done_q    <= 1'b0;
      wr_error_q   <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_word_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wvalid_q     <= wvalid_d;
      fill_line_q  <= fill_line_d;
      fill_valid_q <= fill_valid_d;
      fill_error_q <= fill_error_d;
      wr_done_q    <= wr_done_d;
      wr_error_q   <= wr_error_d;
`ifdef CRITICAL_WORD_FIRST_EN
      start_word_q <= start_word_d;
`endif
    end
  end

  assign fill_valid = fill_valid_q;
  assign fill_error = fill_error_q;
  assign fill_line  = fill_line_q;
  assign wr_done    = wr_done_q;
  assign wr_error   = wr_error_q;

  // Burst attributes are only driven while their channel is valid so the bus idles at zero.
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arvalid_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign m_axi.arsize  = arvalid_q ? 3'(OFF_BITS) : 3'd0;
  assign m_axi.arburst = arvalid_q ? RD_BURST : 2'b00;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == RDATA);
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = awvalid_q ? 3'(OFF_BITS) : 3'd0;
  assign m_axi.awburst = awvalid_q ? 2'b01 : 2'b00;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = wvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state_q == BRESP);
endmodule
